// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (legacy 0001..1000, extended 1001..1100)
//   - FSM state and iterative-engine mode enums
//   - width helper for the iteration counter (must hold the value WIDTH)
package alu_pkg;

   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_CMP  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_MOV  = 4'b0110;
   localparam logic [3:0] OP_MOVI = 4'b0111;
   localparam logic [3:0] OP_ADD  = 4'b1000;
   localparam logic [3:0] OP_LSL  = 4'b1001;
   localparam logic [3:0] OP_LSR  = 4'b1010;
   localparam logic [3:0] OP_ASR  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ITER = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      IT_LSL = 2'd0,
      IT_LSR = 2'd1,
      IT_ASR = 2'd2,
      IT_MUL = 2'd3
   } iter_mode_e;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/alu_iter.sv
// alu_iter: iterative shift / shift-add multiply engine.
//   clk, reset   clock and synchronous active-high reset
//   load         capture operands, mode and iteration count
//   step         perform one iteration (one shift bit / one multiplier bit)
//   mode         2-bit iter_mode_e encoding
//   a, b         operands (a = value to shift / multiplicand, b = multiplier)
//   cnt_init     number of iterations to perform
//   last         no iterations remain; result is final
//   result       accumulator
module alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CNT_W-1:0] cnt_init,
   output logic             last,
   output logic [WIDTH-1:0] result
);

   iter_mode_e       mode_q, mode_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      mode_d   = mode_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (load) begin
         mode_d   = iter_mode_e'(mode);
         cnt_d    = cnt_init;
         mcand_d  = a;
         mplier_d = b;
         acc_d    = (iter_mode_e'(mode) == IT_MUL) ? '0 : a;
      end else if (step) begin
         cnt_d = cnt_q - CNT_W'(1);
         unique case (mode_q)
            IT_LSL: acc_d = {acc_q[WIDTH-2:0], 1'b0};
            IT_LSR: acc_d = {1'b0, acc_q[WIDTH-1:1]};
            IT_ASR: acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            IT_MUL: begin
               // Add the shifted multiplicand for each set multiplier bit, LSB first.
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
               mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            end
            default: acc_d = acc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= IT_LSL;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         mode_q   <= mode_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign last   = (cnt_q == '0);
   assign result = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake.
//   clk, reset         clock, synchronous active-high reset
//   start              issue op (ignored while busy)
//   aluControl         4-bit opcode, sampled with start
//   a, b               operands, sampled with start
//   busy               op in progress (EXEC/ITER)
//   done               one-cycle pulse, result/flags valid from this cycle
//   result             registered result, held between ops
//   C, L, F, Z, N      registered flag bits
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       aluControl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             C,
   output logic             L,
   output logic             F,
   output logic             Z,
   output logic             N
);

   localparam int unsigned SH_W  = $clog2(WIDTH);
   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_q, c_d, l_q, l_d, f_q, f_d, z_q, z_d, n_q, n_d;

   logic             iter_load, iter_step, iter_last;
   logic [1:0]       iter_mode;
   logic [CNT_W-1:0] iter_cnt;
   logic             iter_needed;
   logic [WIDTH-1:0] iter_result;
   logic [WIDTH:0]   sum_w, diff_w;

   // Decode of the incoming opcode for the iterative engine.
   always_comb begin
      iter_mode   = IT_MUL;
      iter_cnt    = CNT_W'(b[SH_W-1:0]);
      iter_needed = 1'b0;
      unique case (aluControl)
         OP_LSL: begin iter_mode = IT_LSL; iter_needed = (b[SH_W-1:0] != '0); end
         OP_LSR: begin iter_mode = IT_LSR; iter_needed = (b[SH_W-1:0] != '0); end
         OP_ASR: begin iter_mode = IT_ASR; iter_needed = (b[SH_W-1:0] != '0); end
         OP_MUL: begin iter_cnt = CNT_W'(WIDTH); iter_needed = MUL_EN; end
         default: ;
      endcase
   end

   assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
   assign diff_w = {1'b0, a_q} - {1'b0, b_q};

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      c_d       = c_q;
      l_d       = l_q;
      f_d       = f_q;
      z_d       = z_q;
      n_d       = n_q;
      iter_load = 1'b0;
      iter_step = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               op_d = aluControl;
               a_d  = a;
               b_d  = b;
               if (iter_needed) begin
                  state_d   = ST_ITER;
                  iter_load = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            unique case (op_q)
               OP_SUB: begin
                  result_d = diff_w[WIDTH-1:0];
                  c_d      = diff_w[WIDTH];
                  f_d      = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (diff_w[WIDTH-1] != a_q[WIDTH-1]);
               end
               OP_CMP: begin
                  result_d = '0;
                  l_d      = (a_q < b_q);
                  n_d      = ($signed(a_q) < $signed(b_q));
                  z_d      = (a_q == b_q);
               end
               OP_AND:  result_d = a_q & b_q;
               OP_OR:   result_d = a_q | b_q;
               OP_XOR:  result_d = a_q ^ b_q;
               OP_MOV:  result_d = a_q;
               OP_MOVI: result_d = b_q;
               OP_ADD: begin
                  result_d = sum_w[WIDTH-1:0];
                  c_d      = sum_w[WIDTH];
                  f_d      = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (sum_w[WIDTH-1] != a_q[WIDTH-1]);
               end
               // Shifts reach EXEC only with a zero shift amount.
               OP_LSL, OP_LSR, OP_ASR: result_d = a_q;
               default: result_d = '0;
            endcase
         end
         ST_ITER: begin
            if (iter_last) begin
               state_d  = ST_DONE;
               result_d = iter_result;
            end else begin
               iter_step = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         c_q      <= 1'b0;
         l_q      <= 1'b0;
         f_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         c_q      <= c_d;
         l_q      <= l_d;
         f_q      <= f_d;
         z_q      <= z_d;
         n_q      <= n_d;
      end
   end

   alu_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk      (clk),
      .reset    (reset),
      .load     (iter_load),
      .step     (iter_step),
      .mode     (iter_mode),
      .a        (a),
      .b        (b),
      .cnt_init (iter_cnt),
      .last     (iter_last),
      .result   (iter_result)
   );

   assign busy   = (state_q == ST_EXEC) || (state_q == ST_ITER);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign C      = c_q;
   assign L      = l_q;
   assign F      = f_q;
   assign Z      = z_q;
   assign N      = n_q;

endmodule
